fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write port among NREQ requesters in the write clock domain. Each requester presents a word with `req`. The arbiter picks one winner per cycle, drives the FIFO `w_en`/`wdata` directly and returns a single-cycle `ack` to the winner. It never writes while `wfull` is high, so FIFO overflow cannot occur from this side. An optional burst mode lets a winner keep the port for up to MAXBURST consecutive words.

---
 rtl/fifo_wr_arbiter_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Burst mode is enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Ceiling log2, never less than 1 so a width is always legal.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int idx_width(input int nreq);
        return clog2(nreq);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
// The master modport is the arbiter; the slave modport is requesters plus FIFO.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 16
);
    // req[i] is valid and held with its word until ack[i]; ack[i] and w_en
    // coincide with the edge at which the FIFO captures wdata.
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  wfull;
    logic                  w_en;
    logic [DSIZE-1:0]      wdata;

    modport master (
        input  req, req_data, wfull,
        output ack, w_en, wdata
    );

    modport slave (
        output req, req_data, wfull,
        input  ack, w_en, wdata
    );

endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module fifo_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        valid   = 1'b0;
        pos     = '0;
        pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, start} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(NREQ)) pos = pos - (IDX_W + 1)'(NREQ);
            pos_idx = pos[IDX_W-1:0];
            if (!valid && req[pos_idx]) begin
                valid        = 1'b1;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Defining FIFO_ARB_BURST_EN lets a winner hold the port for up to MAXBURST words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 16,
    parameter int MAXBURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    fifo_wr_arbiter_if.master          bus,
    output logic [idx_width(NREQ)-1:0] owner,
    output logic                       busy
);

    localparam int IDX_W = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 16 || MAXBURST < 1 || MAXBURST > 255) begin : g_bad_params
    end

    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] start_idx, pick_idx;
    logic [NREQ-1:0]  pick_gnt;
    logic             pick_valid;
    logic [DSIZE-1:0] words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*DSIZE +: DSIZE];
    end

    assign start_idx = (last_q == IDX_W'(NREQ - 1)) ? '0 : last_q + 1'b1;

    fifo_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .start (start_idx),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = clog2(MAXBURST + 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        bus.ack   = '0;
        bus.w_en  = 1'b0;
        bus.wdata = '0;
        last_d    = last_q;
        owner_d   = owner_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        // A full FIFO freezes everything, including an open burst.
        if (!wrst && !bus.wfull) begin
            if (state_q == LOCK && bus.req[owner_q]) begin
                bus.ack[owner_q] = 1'b1;
                bus.w_en         = 1'b1;
                bus.wdata        = words[owner_q];
                last_d           = owner_q;
                if (cnt_inc == CNT_W'(MAXBURST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (pick_valid) begin
                bus.ack   = pick_gnt;
                bus.w_en  = 1'b1;
                bus.wdata = words[pick_idx];
                last_d    = pick_idx;
                owner_d   = pick_idx;
                if (MAXBURST > 1) begin
                    state_d = LOCK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            last_q  <= IDX_W'(NREQ - 1);
            owner_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == LOCK);
`else
    always_comb begin
        bus.ack   = '0;
        bus.w_en  = 1'b0;
        bus.wdata = '0;
        last_d    = last_q;
        owner_d   = owner_q;
        if (!wrst && !bus.wfull && pick_valid) begin
            bus.ack   = pick_gnt;
            bus.w_en  = 1'b1;
            bus.wdata = words[pick_idx];
            last_d    = pick_idx;
            owner_d   = pick_idx;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            last_q  <= IDX_W'(NREQ - 1);
            owner_q <= '0;
        end else begin
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign busy = 1'b0;
`endif

    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DSIZE=16, MAXBURST=4).
// Runs the burst sequence when FIFO_ARB_BURST_EN is defined, else the round-robin one.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 16;
    localparam int MAXBURST = 4;

    logic       wclk;
    logic       wrst;
    logic [1:0] owner;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DSIZE-1:0] exp_q[$];
    logic [DSIZE-1:0] exp_w;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk  (wclk),
        .wrst  (wrst),
        .bus   (bus),
        .owner (owner),
        .busy  (busy)
    );

    // clock / reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_ack, input logic e_wen,
                           input logic [15:0] e_wdata);
        chk({tag, ".ack"}, 32'(bus.ack), 32'(e_ack));
        chk({tag, ".w_en"}, 32'(bus.w_en), 32'(e_wen));
        chk({tag, ".wdata"}, 32'(bus.wdata), 32'(e_wdata));
    endtask

    task automatic do_reset(input logic [3:0] r);
        wrst    = 1'b1;
        bus.req = r;
        tick();
        chk_out("rst_c1", 4'b0000, 1'b0, 16'h0000);
        tick();
        chk_out("rst_c2", 4'b0000, 1'b0, 16'h0000);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        wrst = 1'b0;
        settle();
    endtask

    initial begin
        wrst         = 1'b1;
        bus.req      = 4'b1111;
        bus.wfull    = 1'b0;
        bus.req_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

`ifdef FIFO_ARB_BURST_EN
        // Burst: requesters 0 and 2 take turns in blocks of MAXBURST words.
        do_reset(4'b0101);
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < MAXBURST; w++) begin
                chk_out($sformatf("burst_b%0d_w%0d", b, w), (b == 0) ? 4'b0001 : 4'b0100,
                        1'b1, (b == 0) ? 16'hAAAA : 16'hCCCC);
                chk($sformatf("burst_busy_b%0d_w%0d", b, w), 32'(busy), (w == 0) ? 32'd0 : 32'd1);
                tick();
            end
        end
        chk_out("burst_back0", 4'b0001, 1'b1, 16'hAAAA);

        // Early release: owner 0 drops after two words, requester 3 wins at once.
        do_reset(4'b1001);
        chk_out("early_w0", 4'b0001, 1'b1, 16'hAAAA);
        tick();
        chk_out("early_w1", 4'b0001, 1'b1, 16'hAAAA);
        tick();
        bus.req = 4'b1000;
        settle();
        chk_out("early_sw", 4'b1000, 1'b1, 16'hDDDD);
        chk("early_busy", 32'(busy), 32'd1);
        tick();
        chk("early_owner", 32'(owner), 32'd3);

        // Full during a burst holds the lock.
        bus.wfull = 1'b1;
        bus.req   = 4'b1001;
        settle();
        chk_out("lockfull", 4'b0000, 1'b0, 16'h0000);
        tick();
        chk("lockfull_busy", 32'(busy), 32'd1);
        bus.wfull = 1'b0;
        settle();
        chk_out("lockfull_rel", 4'b1000, 1'b1, 16'hDDDD);
`else
        // Reset with every requester active, then requester 0 first.
        do_reset(4'b1111);
        chk_out("first", 4'b0001, 1'b1, 16'hAAAA);

        // Rotation across all four requesters and back to 0.
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'hBBBB);
        exp_q.push_back(16'hCCCC);
        exp_q.push_back(16'hDDDD);
        exp_q.push_back(16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            exp_w = exp_q.pop_front();
            chk_out($sformatf("rot%0d", i), 4'(1 << (i % 4)), 1'b1, exp_w);
            tick();
            chk($sformatf("rot_owner%0d", i), 32'(owner), 32'(i % 4));
        end

        // Full stall after requester 1 is acked.
        chk_out("pre_full", 4'b0010, 1'b1, 16'hBBBB);
        tick();
        bus.wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_out($sformatf("full%0d", i), 4'b0000, 1'b0, 16'h0000);
            chk($sformatf("full_owner%0d", i), 32'(owner), 32'd1);
            tick();
        end
        bus.wfull = 1'b0;
        settle();
        chk_out("post_full", 4'b0100, 1'b1, 16'hCCCC);
        tick();

        // Single requester at the top index wraps onto itself.
        bus.req      = 4'b1000;
        bus.req_data = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        for (int i = 0; i < 6; i++) begin
            settle();
            chk_out($sformatf("single%0d", i), 4'b1000, 1'b1, 16'h1234);
            tick();
            chk($sformatf("single_owner%0d", i), 32'(owner), 32'd3);
        end

        // Sparse requests: pointer at 3, so 1 beats 2.
        bus.req = 4'b0110;
        settle();
        chk_out("sparse_a", 4'b0010, 1'b1, 16'h9ABC);
        tick();
        chk_out("sparse_b", 4'b0100, 1'b1, 16'h5678);
        tick();

        // Nothing requested.
        bus.req = 4'b0000;
        settle();
        chk_out("idle", 4'b0000, 1'b0, 16'h0000);
        tick();
        chk("idle_owner", 32'(owner), 32'd2);

        // Mid-operation reset restores requester 0 priority.
        bus.req = 4'b1111;
        wrst    = 1'b1;
        settle();
        chk_out("midrst", 4'b0000, 1'b0, 16'h0000);
        tick();
        chk("midrst_owner", 32'(owner), 32'd0);
        wrst = 1'b0;
        settle();
        chk_out("midrst_rel", 4'b0001, 1'b1, 16'hDEF0);
        chk("busy_tied", 32'(busy), 32'd0);
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
